// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and types for the LED-matrix / 7-seg scan block.
//   ROWS/COLS  : matrix geometry (8x8)
//   PIX_OFF    : all-columns-dark pattern for the active-low column drive
//   SEG_BLANK  : all-segments-off pattern for the active-low segment drive
//   COMM_*     : digit-enable codes for the two score digits
//   scan_state_t : row scheduler states
package scan_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam logic [COLS-1:0] PIX_OFF   = 8'hFF;
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    localparam logic [1:0] COMM_TENS  = 2'b10;
    localparam logic [1:0] COMM_UNITS = 2'b01;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_FETCH,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder.
//   bcd : in  4  digit value; 10..15 display as blank
//   seg : out 7  segment pattern {A..G}, active-low (0 = segment lit)
module seg7_decode
    import scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: row-scan scheduler for the 8x8 RGB LED matrix and the
// 2-digit 7-seg score display.
//   clk, clear            : clock; asynchronous active-high reset
//   row_req, row_idx      : one-cycle fetch strobe and the row being fetched/shown
//   row_vld               : frame store has placed the row's layers on the inputs
//   body/red/green/ovl_row: layers, active-low; overlay_en selects ovl_row alone
//   bcd_hi, bcd_lo        : score digits
//   data_r/g/b            : column drive, active-low
//   comm                  : {1'b1,row} row select
//   d7_1, COMM_CLK        : segment pattern and digit enable (10 tens, 01 units)
//   frame_start           : one-cycle pulse when the row wraps 7->0
//   fetch_err             : sticky, a row slot ended without data
module matrix_scan_ctrl
    import scan_pkg::*;
#(
    parameter int SCAN_DIV  = 10001,
    parameter int BLANK_CYC = 4
) (
    input  logic             clk,
    input  logic             clear,
    output logic             row_req,
    output logic [2:0]       row_idx,
    input  logic             row_vld,
    input  logic [COLS-1:0]  body_row,
    input  logic [COLS-1:0]  red_row,
    input  logic [COLS-1:0]  green_row,
    input  logic [COLS-1:0]  ovl_row,
    input  logic             overlay_en,
    input  logic [3:0]       bcd_hi,
    input  logic [3:0]       bcd_lo,
    output logic [COLS-1:0]  data_r,
    output logic [COLS-1:0]  data_g,
    output logic [COLS-1:0]  data_b,
    output logic [3:0]       comm,
    output logic [6:0]       d7_1,
    output logic [1:0]       COMM_CLK,
    output logic             frame_start,
    output logic             fetch_err
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLANK_CYC + 1);

    scan_state_t   state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] blank_cnt, blank_nxt;
    logic          tick;
    logic          req_nxt;
    logic          take_row;
    logic [3:0]    digit_nxt;
    logic [6:0]    seg_nxt;

    assign tick = (tick_cnt == TW'(SCAN_DIV - 1));
    assign comm = {1'b1, row_idx};

    // Decode the digit that becomes enabled at the next tick, so d7_1 and
    // COMM_CLK change on the same edge.
    assign digit_nxt = (COMM_CLK == COMM_TENS) ? bcd_lo : bcd_hi;

    seg7_decode u_seg (
        .bcd (digit_nxt),
        .seg (seg_nxt)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= ST_BLANK;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
        end
    end

    // Tick overrides every state: a row slot always ends on schedule.
    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        req_nxt   = 1'b0;
        take_row  = 1'b0;
        if (tick) begin
            state_nxt = ST_BLANK;
            blank_nxt = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (blank_cnt == BW'(BLANK_CYC - 1)) begin
                        state_nxt = ST_FETCH;
                        req_nxt   = 1'b1;
                        blank_nxt = '0;
                    end else begin
                        blank_nxt = blank_cnt + 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (row_vld) begin
                        state_nxt = ST_SHOW;
                        take_row  = 1'b1;
                    end
                end
                ST_SHOW:  state_nxt = ST_SHOW;
                default:  state_nxt = ST_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            tick_cnt    <= '0;
            row_req     <= 1'b0;
            row_idx     <= '0;
            data_r      <= PIX_OFF;
            data_g      <= PIX_OFF;
            data_b      <= PIX_OFF;
            d7_1        <= SEG_BLANK;
            COMM_CLK    <= COMM_TENS;
            frame_start <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            row_req     <= req_nxt;
            frame_start <= tick && (row_idx == 3'(ROWS - 1));
            if (tick) begin
                row_idx  <= row_idx + 1'b1;
                data_r   <= PIX_OFF;
                data_g   <= PIX_OFF;
                data_b   <= PIX_OFF;
                COMM_CLK <= (COMM_CLK == COMM_TENS) ? COMM_UNITS : COMM_TENS;
                d7_1     <= seg_nxt;
                if (state != ST_SHOW)
                    fetch_err <= 1'b1;
            end else if (take_row) begin
                if (overlay_en) begin
                    data_b <= ovl_row;
                    data_r <= PIX_OFF;
                    data_g <= PIX_OFF;
                end else begin
                    // A lit body pixel masks red and green; a lit red masks green.
                    data_b <= body_row;
                    data_r <= red_row | ~body_row;
                    data_g <= green_row | ~body_row | ~red_row;
                end
            end
        end
    end

endmodule
